// File: rtl/freq_sweep_pkg.sv
// Shared definitions for the frequency sweep controller: mode encodings,
// controller state type and default sizing constants.
package freq_sweep_pkg;

   localparam int DEF_FREQ_W   = 20;
   localparam int DEF_DWELL_W  = 24;
   localparam int DEF_MAX_FREQ = 999_999;

   localparam logic [1:0] SWEEP_SINGLE = 2'b00;
   localparam logic [1:0] SWEEP_SAW    = 2'b01;
   localparam logic [1:0] SWEEP_TRI    = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      HOLD  = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable dwell down-counter; expire is high while enabled and the count
// has reached zero, i.e. during the last cycle of the current dwell.
module sweep_dwell_timer
   import freq_sweep_pkg::*;
#(
   parameter int W = DEF_DWELL_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Linear frequency sweep controller feeding the NCO phase accumulator.
// Define SWEEP_CNT_EN to add the saturating sweep_count output.
module freq_sweep_ctrl
   import freq_sweep_pkg::*;
#(
   parameter int FREQ_W   = DEF_FREQ_W,
   parameter int DWELL_W  = DEF_DWELL_W,
   parameter int MAX_FREQ = DEF_MAX_FREQ
`ifdef SWEEP_CNT_EN
   ,
   parameter int CNT_W    = 16
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [FREQ_W-1:0]  freq_manual,
   input  logic               start,
   input  logic               stop,
   input  logic [FREQ_W-1:0]  f_start,
   input  logic [FREQ_W-1:0]  f_stop,
   input  logic [FREQ_W-1:0]  step_hz,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [1:0]         mode,
   output logic [FREQ_W-1:0]  freq_word,
   output logic               freq_upd,
   output logic               busy,
   output logic               done,
   output logic               wrap,
   output logic               dir_down
`ifdef SWEEP_CNT_EN
   ,
   output logic [CNT_W-1:0]   sweep_count
`endif
);

   localparam logic [FREQ_W-1:0] MAX_F = FREQ_W'(MAX_FREQ);

   sweep_state_t       state;
   logic [FREQ_W-1:0]  sh_start;
   logic [FREQ_W-1:0]  sh_stop;
   logic [FREQ_W-1:0]  sh_step;
   logic [FREQ_W-1:0]  target;
   logic [DWELL_W-1:0] sh_dwell_m1;
   logic [1:0]         sh_mode;

   logic [FREQ_W-1:0]  in_start_c;
   logic [FREQ_W-1:0]  in_stop_c;
   logic [DWELL_W-1:0] in_dwell_m1;
   logic               degenerate;
   logic               at_target;
   logic               step_down;
   logic [FREQ_W-1:0]  step_target;
   logic [FREQ_W-1:0]  step_next;
   logic               is_single;
   logic               timer_load;
   logic [DWELL_W-1:0] timer_val;
   logic               expire;

   // Widened by one bit so cur+step can never wrap past the target.
   function automatic logic [FREQ_W-1:0] next_freq(
      input logic [FREQ_W-1:0] cur,
      input logic [FREQ_W-1:0] tgt,
      input logic [FREQ_W-1:0] stp,
      input logic              down
   );
      logic [FREQ_W:0] sum;
      logic [FREQ_W:0] diff;
      sum  = {1'b0, cur} + {1'b0, stp};
      diff = {1'b0, cur} - {1'b0, tgt};
      if (down)
         next_freq = (diff <= {1'b0, stp}) ? tgt : cur - stp;
      else
         next_freq = (sum >= {1'b0, tgt}) ? tgt : sum[FREQ_W-1:0];
   endfunction

   always_comb begin
      in_start_c  = (f_start > MAX_F) ? MAX_F : f_start;
      in_stop_c   = (f_stop > MAX_F) ? MAX_F : f_stop;
      in_dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
      degenerate  = (step_hz == '0) || (in_start_c == in_stop_c);
      at_target   = (freq_word == target);
      is_single   = !(sh_mode == SWEEP_SAW || sh_mode == SWEEP_TRI);
      // At a triangle endpoint the next step heads back toward the other end.
      step_target = at_target ? ((target == sh_stop) ? sh_start : sh_stop) : target;
      step_down   = at_target ? ~dir_down : dir_down;
      step_next   = next_freq(freq_word, step_target, sh_step, step_down);
      timer_load  = start || (state == SWEEP && expire);
      timer_val   = start ? in_dwell_m1 : sh_dwell_m1;
   end

   sweep_dwell_timer #(
      .W (DWELL_W)
   ) u_dwell (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .en       (state == SWEEP),
      .load_val (timer_val),
      .expire   (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         freq_word   <= '0;
         freq_upd    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         wrap        <= 1'b0;
         dir_down    <= 1'b0;
         sh_start    <= '0;
         sh_stop     <= '0;
         sh_step     <= '0;
         sh_dwell_m1 <= '0;
         sh_mode     <= SWEEP_SINGLE;
         target      <= '0;
      end else begin
         freq_upd <= 1'b0;
         done     <= 1'b0;
         wrap     <= 1'b0;
         if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dir_down  <= 1'b0;
            freq_word <= freq_manual;
         end else if (start) begin
            sh_start    <= in_start_c;
            sh_stop     <= in_stop_c;
            sh_step     <= step_hz;
            sh_dwell_m1 <= in_dwell_m1;
            sh_mode     <= mode;
            target      <= in_stop_c;
            dir_down    <= (in_stop_c < in_start_c);
            freq_word   <= in_start_c;
            freq_upd    <= 1'b1;
            if (degenerate) begin
               state <= HOLD;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               state <= SWEEP;
               busy  <= 1'b1;
            end
         end else begin
            case (state)
               IDLE: freq_word <= freq_manual;
               SWEEP: begin
                  if (expire) begin
                     if (at_target && is_single) begin
                        state <= HOLD;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else if (at_target && sh_mode == SWEEP_SAW) begin
                        freq_word <= sh_start;
                        freq_upd  <= 1'b1;
                        wrap      <= 1'b1;
                     end else if (at_target) begin
                        freq_word <= step_next;
                        freq_upd  <= 1'b1;
                        wrap      <= 1'b1;
                        dir_down  <= step_down;
                        target    <= step_target;
                     end else begin
                        freq_word <= step_next;
                        freq_upd  <= 1'b1;
                     end
                  end
               end
               HOLD: state <= HOLD;
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SWEEP_CNT_EN
   // Counts endpoint events; a fresh start restarts the tally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_count <= '0;
      end else if (start && !stop) begin
         sweep_count <= '0;
      end else if ((done || wrap) && sweep_count != '1) begin
         sweep_count <= sweep_count + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed self-checking bench for freq_sweep_ctrl (default build).
`timescale 1ns/1ps
module tb_freq_sweep_ctrl;

   logic        clk;
   logic        rst_n;
   logic [19:0] freq_manual;
   logic        start;
   logic        stop;
   logic [19:0] f_start;
   logic [19:0] f_stop;
   logic [19:0] step_hz;
   logic [23:0] dwell;
   logic [1:0]  mode;
   logic [19:0] freq_word;
   logic        freq_upd;
   logic        busy;
   logic        done;
   logic        wrap;
   logic        dir_down;

   int checks = 0;
   int errors = 0;

   freq_sweep_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .freq_manual (freq_manual),
      .start       (start),
      .stop        (stop),
      .f_start     (f_start),
      .f_stop      (f_stop),
      .step_hz     (step_hz),
      .dwell       (dwell),
      .mode        (mode),
      .freq_word   (freq_word),
      .freq_upd    (freq_upd),
      .busy        (busy),
      .done        (done),
      .wrap        (wrap),
      .dir_down    (dir_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_sweep(input int fs, input int fe, input int st, input int dw, input logic [1:0] md);
      f_start = 20'(fs);
      f_stop  = 20'(fe);
      step_hz = 20'(st);
      dwell   = 24'(dw);
      mode    = md;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic test_reset();
      logic [24:0] got, want;
      rst_n = 1'b0; start = 0; stop = 0; freq_manual = 20'd1000;
      f_start = 0; f_stop = 0; step_hz = 0; dwell = 0; mode = 0;
      #3;
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd0, 5'b00000};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL reset_values got=%h expected=%h", got, want);
      end
      tick();
      rst_n = 1'b1;
      tick();
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd1000, 5'b00000};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL idle_passthrough got=%h expected=%h", got, want);
      end
   endtask

   task automatic test_single_up();
      int seq [4] = '{1000, 1100, 1200, 1250};
      logic [24:0] got, want;
      start_sweep(1000, 1250, 100, 4, 2'b00);
      for (int k = 0; k < 16; k++) begin
         got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
         want = {20'(seq[k/4]), (k % 4 == 0), 1'b1, 3'b000};
         checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL single_up k=%0d got=%h expected=%h", k, got, want);
         end
         if (k == 1) begin
            f_start = 20'd5; f_stop = 20'd7; step_hz = 20'd1; dwell = 24'd9; mode = 2'b10;
         end
         tick();
      end
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd1250, 5'b00100};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL single_up_done got=%h expected=%h", got, want);
      end
      tick();
      tick();
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd1250, 5'b00000};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL single_up_hold got=%h expected=%h", got, want);
      end
   endtask

   task automatic test_restart_from_hold();
      int seq [4] = '{50, 20, 10, 10};
      logic [24:0] got, want;
      start_sweep(50, 10, 30, 1, 2'b00);
      for (int k = 0; k < 4; k++) begin
         got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
         want = (k < 3) ? {20'(seq[k]), 5'b11001} : {20'(seq[k]), 5'b00101};
         checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL restart_down k=%0d got=%h expected=%h", k, got, want);
         end
         tick();
      end
   endtask

   task automatic test_triangle();
      int   seq [9]   = '{500, 400, 300, 200, 300, 400, 500, 400, 300};
      logic wexp [9]  = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
      logic dexp [9]  = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
      logic [24:0] got, want;
      start_sweep(500, 200, 100, 1, 2'b10);
      for (int k = 0; k < 9; k++) begin
         got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
         want = {20'(seq[k]), 1'b1, 1'b1, 1'b0, wexp[k], dexp[k]};
         checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL triangle k=%0d got=%h expected=%h", k, got, want);
         end
         tick();
      end
   endtask

   task automatic test_sawtooth();
      int   seq [10]  = '{0, 0, 150, 150, 300, 300, 0, 0, 150, 150};
      logic [24:0] got, want;
      start_sweep(0, 300, 150, 2, 2'b01);
      for (int k = 0; k < 10; k++) begin
         got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
         want = {20'(seq[k]), (k % 2 == 0), 1'b1, 1'b0, (k == 6), 1'b0};
         checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL sawtooth k=%0d got=%h expected=%h", k, got, want);
         end
         tick();
      end
   endtask

   task automatic test_clamp();
      int seq [4] = '{999_700, 999_900, 999_999, 999_999};
      logic [24:0] got, want;
      start_sweep(1_048_575, 1_048_575, 5, 3, 2'b00);
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd999_999, 5'b10100};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL clamp_both got=%h expected=%h", got, want);
      end
      start_sweep(999_700, 1_048_575, 200, 1, 2'b00);
      for (int k = 0; k < 4; k++) begin
         got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
         want = (k < 3) ? {20'(seq[k]), 5'b11000} : {20'(seq[k]), 5'b00100};
         checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL clamp_stop k=%0d got=%h expected=%h", k, got, want);
         end
         tick();
      end
   endtask

   task automatic test_step_zero();
      logic [24:0] got, want;
      start_sweep(4321, 9000, 0, 5, 2'b01);
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd4321, 5'b10100};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL step_zero got=%h expected=%h", got, want);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
         want = {20'd4321, 5'b00000};
         checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL step_zero_hold k=%0d got=%h expected=%h", k, got, want);
         end
      end
   endtask

   task automatic test_mode3_dwell0();
      int seq [3] = '{0, 100, 100};
      logic [24:0] got, want;
      start_sweep(0, 100, 100, 0, 2'b11);
      for (int k = 0; k < 3; k++) begin
         got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
         want = (k < 2) ? {20'(seq[k]), 5'b11000} : {20'(seq[k]), 5'b00100};
         checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL mode3_dwell0 k=%0d got=%h expected=%h", k, got, want);
         end
         tick();
      end
   endtask

   task automatic test_abort();
      logic [24:0] got, want;
      start_sweep(1000, 2000, 100, 3, 2'b00);
      tick(); tick(); tick();
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd1100, 5'b11000};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL abort_presweep got=%h expected=%h", got, want);
      end
      tick();
      freq_manual = 20'd777;
      f_start = 20'd3000;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd777, 5'b00000};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL abort_priority got=%h expected=%h", got, want);
      end
      freq_manual = 20'd778;
      for (int k = 0; k < 2; k++) begin
         tick();
         got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
         want = {20'd778, 5'b00000};
         checks++;
         if (got !== want) begin
            errors++;
            $display("[TB] FAIL abort_idle k=%0d got=%h expected=%h", k, got, want);
         end
      end
   endtask

   task automatic test_reset_midsweep();
      logic [24:0] got, want;
      start_sweep(300, 0, 150, 2, 2'b01);
      tick(); tick();
      rst_n = 1'b0;
      #2;
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd0, 5'b00000};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL reset_midsweep got=%h expected=%h", got, want);
      end
      tick();
      rst_n = 1'b1;
      freq_manual = 20'd55;
      tick();
      got  = {freq_word, freq_upd, busy, done, wrap, dir_down};
      want = {20'd55, 5'b00000};
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL reset_recover got=%h expected=%h", got, want);
      end
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_restart_from_hold();
      test_triangle();
      test_sawtooth();
      test_clamp();
      test_step_zero();
      test_mode3_dwell0();
      test_abort();
      test_reset_midsweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_sweep_ctrl.md
Name: freq_sweep_ctrl

Overview:
Upstream stage of the NCO phase accumulator. Produces the 20-bit frequency word in Hz that drives freq_word. In IDLE it passes a manual frequency through. On start it steps linearly from a start to a stop frequency with a programmable dwell per step, in single, sawtooth or triangle mode.

Parameters:
FREQ_W, 20, width of all frequency quantities (Hz)
DWELL_W, 24, width of dwell counter (clock cycles per step)
MAX_FREQ, 999_999, upper clamp applied to captured f_start/f_stop
CNT_W, 16, width of sweep counter (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
freq_manual  in  FREQ_W  frequency passed through while IDLE
start  in  1  sweep start pulse; captures all config inputs
stop  in  1  abort; returns to IDLE
f_start  in  FREQ_W  sweep start frequency
f_stop  in  FREQ_W  sweep end frequency
step_hz  in  FREQ_W  frequency increment per step
dwell  in  DWELL_W  cycles each frequency is held (0 treated as 1)
mode  in  2  00 single, 01 sawtooth, 10 triangle, 11 = single
freq_word  out  FREQ_W  registered frequency to phase accumulator
freq_upd  out  1  1-cycle pulse, aligned with each freq_word change from a step/load
busy  out  1  high in SWEEP state
done  out  1  1-cycle pulse on entry to HOLD
wrap  out  1  1-cycle pulse at sawtooth reload / triangle turn-around
dir_down  out  1  current sweep direction (1 = decreasing)

Behaviour:
- Reset: freq_word=0, freq_upd=0, busy=0, done=0, wrap=0, dir_down=0, state IDLE, dwell counter 0.
- States: IDLE, SWEEP, HOLD. All outputs registered.
- IDLE: freq_word <= freq_manual every cycle. freq_upd is not asserted.
- Priority each cycle: stop > start > internal. stop in any state -> IDLE next cycle, busy=0. No done pulse.
- start (IDLE, SWEEP or HOLD): capture f_start/f_stop clamped to MAX_FREQ, plus step_hz, dwell, mode, into shadow regs. Later input changes are ignored until the next start.
- Start latency: start sampled at cycle N -> at N+1 freq_word=f_start, freq_upd=1, busy=1, dir_down=(f_stop<f_start).
- Degenerate start (step_hz==0 or clamped f_start==f_stop): N+1 freq_word=f_start, freq_upd=1, state HOLD, done=1, busy=0.
- SWEEP: each frequency is held exactly max(dwell,1) cycles, counted from its freq_upd cycle. The cycle after the dwell expires, freq_word takes the next value and freq_upd=1.
- Step arithmetic uses FREQ_W+1 bits, with no wrap.
  - Up: next = cur+step; if next >= target, next = target.
  - Down: if cur-target <= step, next = target; else next = cur-step.
- Endpoint handling when the dwell expires at cur == target:
  - single: -> HOLD, done=1, freq_word unchanged, freq_upd=0.
  - sawtooth: freq_word=f_start, freq_upd=1, wrap=1.
  - triangle: toggle dir_down, swap target between f_start and f_stop, step toward the new target (clamped), wrap=1. Runs forever.
- HOLD: freq_word holds the final value until start or stop.
- Reset mid-sweep: immediate return to reset values.

Optional Feature:
SWEEP_CNT_EN.
- Defined: adds output sweep_count [CNT_W-1:0]. Cleared by reset and on each accepted start. Increments on every done or wrap pulse and saturates at all-ones.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package freq_sweep_pkg holds:
  - mode encodings SWEEP_SINGLE=2'b00, SWEEP_SAW=2'b01, SWEEP_TRI=2'b10;
  - state enum (IDLE/SWEEP/HOLD);
  - default FREQ_W/DWELL_W/MAX_FREQ constants.
- One sub-module, sweep_dwell_timer: loadable down-counter with load, enable, and an expire pulse output.

Test Plan:
- Reset then IDLE with freq_manual=1000 -> freq_word=1000 next cycle, freq_upd=0, busy=0.
- Single up sweep: f_start=1000, f_stop=1250, step=100, dwell=4 -> freq_word 1000,1100,1200,1250, each for 4 cycles. done pulses 4 cycles after 1250 appears. HOLD keeps 1250.
- Triangle: f_start=500, f_stop=200, step=100, dwell=1 -> sequence 500,400,300,200,300,400,500,400…. wrap at each turn. dir_down toggles.
- Sawtooth: f_start=0, f_stop=300, step=150, dwell=2 -> 0,150,300,0,…. wrap on each reload to 0.
- Clamp/degenerate: f_stop=1_048_575 clamps to 999_999. step_hz=0 -> immediate HOLD with freq_word=f_start and a single done pulse.
- Abort/priority: start and stop asserted in the same cycle mid-sweep -> IDLE next cycle, freq_word=freq_manual, no done. start while in HOLD -> restarts at new f_start.
